// File: rtl/pipe_rca_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_rca_addsub : pipelined ripple-carry adder/subtractor, one SEG-bit     |
// |                   ripple segment per stage, global stall on backpressure.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_rca_addsub #(
  parameter int WIDTH = 64,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STAGES = WIDTH / SEG;

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  // Subtraction is folded into the operand: A + ~B + 1.
  assign w_b_eff   = Sub ? ~B : B;
  assign w_cin_eff = Sub | Cin;
  assign w_adv     = ~out_valid | out_ready;
  assign in_ready  = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RW = (STAGES - k) * SEG;

    logic [RW-1:0]          w_src_a;
    logic [RW-1:0]          w_src_b;
    logic                   w_cin;
    logic                   w_vin;
    logic [SEG:0]           w_add;
    logic [(k+1)*SEG-1:0]   w_sum_nxt;
    logic [(k+1)*SEG-1:0]   r_sum;
    logic                   r_c;
    logic                   r_v;

    if (k == 0) begin : g_head
      assign w_src_a   = A;
      assign w_src_b   = w_b_eff;
      assign w_cin     = w_cin_eff;
      assign w_vin     = in_valid;
      assign w_sum_nxt = w_add[SEG-1:0];
    end else begin : g_body
      assign w_src_a   = g_stage[k-1].g_hi.r_a;
      assign w_src_b   = g_stage[k-1].g_hi.r_b;
      assign w_cin     = g_stage[k-1].r_c;
      assign w_vin     = g_stage[k-1].r_v;
      assign w_sum_nxt = {w_add[SEG-1:0], g_stage[k-1].r_sum};
    end

    assign w_add = {1'b0, w_src_a[SEG-1:0]} + {1'b0, w_src_b[SEG-1:0]}
                 + {{SEG{1'b0}}, w_cin};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_v <= w_vin;
        if (w_vin) begin
          r_c   <= w_add[SEG];
          r_sum <= w_sum_nxt;
        end
      end
    end

    if (k < STAGES - 1) begin : g_hi
      // Operand segments still waiting for their turn in a later stage.
      logic [RW-SEG-1:0] r_a;
      logic [RW-SEG-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_vin) begin
          r_a <= w_src_a[RW-1:SEG];
          r_b <= w_src_b[RW-1:SEG];
        end
      end
    end else begin : g_tail
      logic r_ovf;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv && w_vin) begin
          r_ovf <= (w_src_a[SEG-1] == w_src_b[SEG-1]) &&
                   (w_add[SEG-1] != w_src_a[SEG-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign Sum       = g_stage[STAGES-1].r_sum;
  assign Cout      = g_stage[STAGES-1].r_c;
  assign Ovf       = g_stage[STAGES-1].g_tail.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_rca_addsub.sv
`default_nettype none
// Bench for pipe_rca_addsub: three instances (64/8, 16/4, 8/8) share one
// stimulus stream; each is scored against an arithmetic reference model.
module tb_pipe_rca_addsub;

  localparam int W   [3] = '{64, 16, 8};
  localparam int LAT [3] = '{8, 4, 1};

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        sub;
  logic [63:0] a;
  logic [63:0] b;
  logic [2:0]  in_rdy;
  logic [2:0]  out_vld;
  logic [2:0]  co;
  logic [2:0]  of;
  logic [63:0] s0;
  logic [15:0] s1;
  logic [7:0]  s2;

  int          checks = 0;
  int          errors = 0;
  logic [65:0] q [3][$];
  logic [2:0]  held = '0;
  logic [65:0] held_val [3];

  pipe_rca_addsub #(.WIDTH(64), .SEG(8)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .A(a), .B(b), .Cin(cin), .Sub(sub), .out_valid(out_vld[0]),
    .out_ready(out_ready), .Sum(s0), .Cout(co[0]), .Ovf(of[0])
  );

  pipe_rca_addsub #(.WIDTH(16), .SEG(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .A(a[15:0]), .B(b[15:0]), .Cin(cin), .Sub(sub), .out_valid(out_vld[1]),
    .out_ready(out_ready), .Sum(s1), .Cout(co[1]), .Ovf(of[1])
  );

  pipe_rca_addsub #(.WIDTH(8), .SEG(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .A(a[7:0]), .B(b[7:0]), .Cin(cin), .Sub(sub), .out_valid(out_vld[2]),
    .out_ready(out_ready), .Sum(s2), .Cout(co[2]), .Ovf(of[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned sum for Sum/Cout, true signed arithmetic for Ovf.
  function automatic logic [65:0] model(input int w, input logic [63:0] a_in,
                                        input logic [63:0] b_in, input logic c_in,
                                        input logic s_in);
    logic [63:0]        mask, aa, bb, bx;
    logic [64:0]        full;
    logic signed [63:0] ta, tb;
    logic signed [66:0] sa, sb, r, maxv, minv;
    logic               ovf;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = a_in & mask;
    bb   = b_in & mask;
    bx   = s_in ? (~bb & mask) : bb;
    full = {1'b0, aa} + {1'b0, bx} + {64'd0, (s_in | c_in)};
    ta   = aa << (64 - w);
    ta   = ta >>> (64 - w);
    tb   = bb << (64 - w);
    tb   = tb >>> (64 - w);
    sa   = ta;
    sb   = tb;
    if (s_in) r = sa - sb;
    else      r = sa + sb + $signed({66'd0, c_in});
    maxv = (67'sd1 <<< (w - 1)) - 67'sd1;
    minv = -(67'sd1 <<< (w - 1));
    ovf  = (r > maxv) || (r < minv);
    return {ovf, full[w], full[63:0] & mask};
  endfunction

  function automatic logic [65:0] got(input int i);
    case (i)
      0:       return {of[0], co[0], s0};
      1:       return {of[1], co[1], 48'd0, s1};
      default: return {of[2], co[2], 56'd0, s2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [65:0] g, input logic [65:0] e);
    checks++;
    assert (g === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, g, e);
    end
  endtask

  task automatic rand_beat();
    logic [31:0] t;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    t = $urandom;
    cin = t[0];
    sub = t[1];
  endtask

  // Scoreboard: record accepted beats, compare every transferred result.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        logic exp_rdy;
        exp_rdy = ~out_vld[i] | out_ready;
        check($sformatf("in_ready%0d", i), {65'd0, in_rdy[i]}, {65'd0, exp_rdy});
        if (held[i] && out_vld[i])
          check($sformatf("hold%0d", i), got(i), held_val[i]);
        held[i]     = out_vld[i] && !out_ready;
        held_val[i] = got(i);
        if (in_valid && in_rdy[i])
          q[i].push_back(model(W[i], a, b, cin, sub));
        if (out_vld[i] && out_ready) begin
          checks++;
          assert (q[i].size() != 0) else begin
            errors++;
            $error("FAIL stray%0d: got %h expected no output", i, got(i));
          end
          if (q[i].size() != 0)
            check($sformatf("result%0d", i), got(i), q[i].pop_front());
        end
      end
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 3; i++) q[i].delete();
    held = '0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic directed(input string tag, input logic [63:0] da, input logic [63:0] db,
                          input logic dc, input logic ds, input logic [65:0] e0,
                          input logic [65:0] e1, input logic [65:0] e2);
    logic [65:0] e [3];
    logic        ev;
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    @(posedge clk); #1;
    a = da; b = db; cin = dc; sub = ds; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        ev = (j == LAT[i] - 1);
        check($sformatf("%s_vld%0d_c%0d", tag, i, j), {65'd0, out_vld[i]}, {65'd0, ev});
        if (ev) check($sformatf("%s_val%0d", tag, i), got(i), e[i]);
      end
    end
  endtask

  initial begin
    int  c;
    int  n;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #3;
    check("rst_vld", {63'd0, out_vld}, 66'd0);
    check("rst_rdy", {63'd0, in_rdy}, 66'd7);
    for (int i = 0; i < 3; i++) check($sformatf("rst_out%0d", i), got(i), 66'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    directed("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
             {2'b01, 64'd0}, {2'b01, 64'd0}, {2'b01, 64'd0});
    directed("borrow", 64'd5, 64'd7, 1'b1, 1'b1,
             {2'b00, 64'hFFFF_FFFF_FFFF_FFFE}, {2'b00, 64'hFFFE}, {2'b00, 64'hFE});
    directed("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             {2'b10, 64'h8000_0000_0000_0000}, {2'b01, 64'd0}, {2'b01, 64'd0});

    // 20 back-to-back beats, out_ready low for cycles 10..14.
    c = 0; n = 0;
    @(posedge clk); #1;
    rand_beat();
    in_valid = 1'b1;
    while (n < 20 && c < 200) begin
      @(negedge clk);
      acc = in_rdy[0];
      @(posedge clk); #1;
      c++;
      if (acc) begin
        n++;
        if (n < 20) rand_beat();
        else        in_valid = 1'b0;
      end
      out_ready = !(c >= 10 && c <= 14);
    end
    check("stream_count", 66'(n), 66'd20);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("stream_drain%0d", i), 66'(q[i].size()), 66'd0);

    // Reset pulse with four beats in flight.
    @(posedge clk); #1;
    rand_beat();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      if (k < 3) begin #1; rand_beat(); end
    end
    #1 in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {63'd0, out_vld}, 66'd0);
    check("mid_rst_rdy", {63'd0, in_rdy}, 66'd7);
    for (int i = 0; i < 3; i++) check($sformatf("mid_rst_out%0d", i), got(i), 66'd0);
    #1 rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check($sformatf("stale_c%0d", j), {63'd0, out_vld}, 66'd0);
    end
    directed("post_rst", 64'd1, 64'd2, 1'b0, 1'b0,
             {2'b00, 64'd3}, {2'b00, 64'd3}, {2'b00, 64'd3});
    repeat (4) @(posedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("final_drain%0d", i), 66'(q[i].size()), 66'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_rca_addsub.md
PIPE_RCA_ADDSUB -- requirements
Module: pipe_rca_addsub

Interface
- REQ-001 SHALL have parameter WIDTH, default 64: operand/result width; must be a multiple of SEG.
- REQ-002 SHALL have parameter SEG, default 8: segment width, one ripple-carry segment per pipeline stage.
- REQ-003 SHALL derive STAGES = WIDTH/SEG; default 8.
- REQ-004 Ports, in order:
  - clk  input  1  single clock; all state on rising edge.
  - rst_n  input  1  reset, asynchronous and active-low.
  - in_valid  input  1  operand beat offered.
  - in_ready  output  1  block accepts the beat this cycle.
  - A  input  WIDTH  operand A.
  - B  input  WIDTH  operand B.
  - Cin  input  1  carry-in; used only when Sub=0.
  - Sub  input  1  0 = add, 1 = subtract.
  - out_valid  output  1  result beat present.
  - out_ready  input  1  downstream accepts result.
  - Sum  output  WIDTH  result.
  - Cout  output  1  carry out of the MSB.
  - Ovf  output  1  two's-complement signed overflow.

Function
- REQ-005 Add (Sub=0): {Cout,Sum} SHALL equal A + B + Cin, computed at WIDTH+1 bits.
- REQ-006 Subtract (Sub=1): {Cout,Sum} SHALL equal A + ~B + 1; Cin is ignored; Cout=1 means no borrow.
- REQ-007 Ovf SHALL be 1 when the MSBs of A and the effective B (B, or ~B when Sub=1) are equal and Sum MSB differs from them; otherwise 0.
- REQ-008 Stage k (0..STAGES-1) SHALL add segment k of A and effective B with the carry registered from stage k-1; stage 0 uses the effective carry-in.
- REQ-009 Each stage SHALL register:
  - its SEG-bit partial sum;
  - its carry-out;
  - the not-yet-added upper segments of the operands;
  - already-computed lower sum segments;
  - a valid bit.
- REQ-010 No carry SHALL propagate combinationally across a stage boundary; the critical path is one SEG-bit ripple.
- REQ-011 Latency SHALL be exactly STAGES cycles from an accepted input (in_valid & in_ready at edge N) to out_valid=1 after edge N+STAGES-1, with no stall.
- REQ-012 Throughput SHALL be one result per cycle while out_ready=1.
- REQ-013 Global advance enable: adv = ~out_valid | out_ready; in_ready SHALL equal adv.
- REQ-014 When adv=0, every stage register, including valid bits, SHALL hold its value.
- REQ-015 While adv=0, Sum/Cout/Ovf/out_valid SHALL remain stable until out_ready=1.
- REQ-016 When adv=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 0. Bubbles are not compressed.
- REQ-017 Beats SHALL exit in acceptance order. None may be dropped or duplicated.
- REQ-018 A beat presented with in_valid=1 while in_ready=0 SHALL NOT be captured.
- REQ-019 Sum/Cout/Ovf are don't-care when out_valid=0 but SHALL NOT be X after reset.
- REQ-020 WIDTH=SEG (STAGES=1) SHALL be legal: single registered stage, latency 1.

Reset
- REQ-021 rst_n=0 SHALL immediately, asynchronously clear:
  - all valid bits, so out_valid=0;
  - Sum=0, Cout=0, Ovf=0;
  - all carry and data registers = 0.
- REQ-022 in_ready SHALL be 1 during and after reset, since out_valid=0.
- REQ-023 Assertion mid-operation SHALL discard all in-flight beats. First capture SHALL occur on the first rising edge with rst_n=1 and in_valid=1.

Verification (WIDTH=64, SEG=8)
- REQ-024 Carry ripple through all stages:
  - Stimulus: A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1, Sub=0, one beat.
  - Response: 8 cycles later out_valid=1, Sum=0, Cout=1, Ovf=0.
- REQ-025 Subtract with borrow:
  - Stimulus: A=5, B=7, Sub=1, Cin=1.
  - Response: Sum=0xFFFF_FFFF_FFFF_FFFE, Cout=0, Ovf=0.
- REQ-026 Signed overflow:
  - Stimulus: A=0x7FFF_FFFF_FFFF_FFFF, B=1, Sub=0, Cin=0.
  - Response: Sum=0x8000_0000_0000_0000, Ovf=1, Cout=0.
- REQ-027 Back-to-back with backpressure:
  - Stimulus: 20 consecutive random beats; out_ready=0 for cycles 10-14.
  - Response: in_ready=0 exactly while out_valid=1 and out_ready=0; held Sum stable; 20 results in order matching the reference model; none lost.
- REQ-028 Reset mid-flight:
  - Stimulus: 4 beats accepted, rst_n pulsed low between clock edges.
  - Response: out_valid=0 at once; no stale beat appears after release; next beat A=1, B=2 yields Sum=3 at latency 8.
- REQ-029 Parameter sweep: repeat REQ-024 and REQ-027 with WIDTH=16/SEG=4 (latency 4) and WIDTH=8/SEG=8 (latency 1).
